// File: rtl/secuenciador.sv
// Next-PC sequencer: PC register, return stack, fixed-priority interrupt vectoring.
// Define SECUENCIADOR_NESTED_INTR_EN to let higher-priority interrupts preempt a running handler.
module secuenciador #(
    parameter int          PC_WIDTH    = 10,
    parameter int          STACK_DEPTH = 8,
    parameter int          N_INTR      = 8,
    parameter int unsigned VEC_BASE    = 'h3E0,
    parameter int unsigned VEC_STRIDE  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               jump,
    input  logic                               call,
    input  logic                               ret,
    input  logic                               reti,
    input  logic [PC_WIDTH-1:0]                target,
    input  logic                               intr_en,
    input  logic [N_INTR-1:0]                  intr,
    output logic [PC_WIDTH-1:0]                pc,
    output logic [N_INTR-1:0]                  intr_ack,
    output logic [N_INTR-1:0]                  in_service,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_ovf,
    output logic                               stack_unf
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int AW   = $clog2(STACK_DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [N_INTR-1:0]   in_service_q, in_service_d;
    logic [N_INTR-1:0]   intr_ack_q, intr_ack_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic                push_en;
    logic [PC_WIDTH-1:0] push_data;

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] stack_top;
    logic [SP_W-1:0]     top_idx;
    logic                stack_full;
    logic                stack_empty;

    logic [N_INTR-1:0]   elig;
    logic [N_INTR-1:0]   grant;
    logic [PC_WIDTH-1:0] vec_tbl [N_INTR];
    logic [PC_WIDTH-1:0] vec_sel;
    logic                take_intr;

    assign pc_inc      = pc_q + PC_WIDTH'(1);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign top_idx     = sp_q - SP_W'(1);
    assign stack_top   = stack_mem[top_idx[AW-1:0]];

    // Per-channel eligibility and vector table.
    for (genvar gi = 0; gi < N_INTR; gi++) begin : g_chan
`ifdef SECUENCIADOR_NESTED_INTR_EN
        assign elig[gi] = intr[gi] & ~(|in_service_q[gi:0]);
`else
        assign elig[gi] = intr[gi] & ~(|in_service_q);
`endif
        assign vec_tbl[gi] = PC_WIDTH'(VEC_BASE + gi * VEC_STRIDE);
    end

    // Isolate the lowest set bit: that is the winning channel.
    assign grant     = elig & (~elig + N_INTR'(1));
    assign take_intr = intr_en & (|elig) & ~stack_full;

    always_comb begin
        vec_sel = '0;
        for (int i = 0; i < N_INTR; i++) begin
            if (grant[i]) begin
                vec_sel = vec_sel | vec_tbl[i];
            end
        end
    end

    always_comb begin
        pc_d         = pc_q;
        sp_d         = sp_q;
        in_service_d = in_service_q;
        intr_ack_d   = '0;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        push_en      = 1'b0;
        push_data    = pc_inc;
        if (stall) begin
            pc_d = pc_q;
        end else if (take_intr) begin
            // The interrupted instruction is re-executed on return, so push pc itself.
            push_en      = 1'b1;
            push_data    = pc_q;
            sp_d         = sp_q + SP_W'(1);
            pc_d         = vec_sel;
            in_service_d = in_service_q | grant;
            intr_ack_d   = grant;
        end else if (reti || ret) begin
            if (stack_empty) begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end else begin
                pc_d = stack_top;
                sp_d = sp_q - SP_W'(1);
            end
            if (reti) begin
                in_service_d = in_service_q & (in_service_q - N_INTR'(1));
            end
        end else if (call) begin
            pc_d = target;
            if (stack_full) begin
                ovf_d = 1'b1;
            end else begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
            end
        end else if (jump) begin
            pc_d = target;
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= '0;
            sp_q         <= '0;
            in_service_q <= '0;
            intr_ack_q   <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            in_service_q <= in_service_d;
            intr_ack_q   <= intr_ack_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    // Stack contents are not reset.
    always_ff @(posedge clk) begin
        if (!reset && push_en) begin
            stack_mem[sp_q[AW-1:0]] <= push_data;
        end
    end

    assign pc         = pc_q;
    assign sp         = sp_q;
    assign in_service = in_service_q;
    assign intr_ack   = intr_ack_q;
    assign stack_ovf  = ovf_q;
    assign stack_unf  = unf_q;

endmodule

// File: tb/tb_secuenciador.sv
// Directed bench for secuenciador: default instance plus a STACK_DEPTH=2 instance for stack limits.
module tb_secuenciador;

    logic       clk = 1'b0;
    logic       reset, stall, jump, call, ret, reti, intr_en;
    logic [9:0] target;
    logic [7:0] intr;

    logic [9:0] pc;
    logic [7:0] intr_ack, in_service;
    logic [3:0] sp;
    logic       stack_ovf, stack_unf;

    logic [9:0] pc2;
    logic [7:0] intr_ack2, in_service2;
    logic [1:0] sp2;
    logic       stack_ovf2, stack_unf2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    secuenciador dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .call(call),
        .ret(ret), .reti(reti), .target(target), .intr_en(intr_en), .intr(intr),
        .pc(pc), .intr_ack(intr_ack), .in_service(in_service), .sp(sp),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    secuenciador #(.STACK_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .call(call),
        .ret(ret), .reti(reti), .target(target), .intr_en(intr_en), .intr(intr),
        .pc(pc2), .intr_ack(intr_ack2), .in_service(in_service2), .sp(sp2),
        .stack_ovf(stack_ovf2), .stack_unf(stack_unf2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctl();
        stall = 0; jump = 0; call = 0; ret = 0; reti = 0;
    endtask

    initial begin
        reset = 1; idle_ctl(); intr_en = 0; intr = '0; target = '0;
        tick(); tick();
        reset = 0;
        chk("reset pc", pc, 0);
        chk("reset sp", sp, 0);
        chk("reset insvc", in_service, 0);
        chk("reset ack", intr_ack, 0);
        chk("reset flags", {stack_ovf, stack_unf}, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("idle pc %0d", k), pc, k);
        end

        // call / ret
        jump = 1; target = 10'h010; tick(); jump = 0;
        chk("jump pc", pc, 10'h010);
        call = 1; target = 10'h100; tick(); call = 0;
        chk("call pc", pc, 10'h100);
        chk("call sp", sp, 1);
        tick(); tick();
        chk("body pc", pc, 10'h102);
        ret = 1; tick(); ret = 0;
        chk("ret pc", pc, 10'h011);
        chk("ret sp", sp, 0);

        // single interrupt, then a higher-priority request while in service
        jump = 1; target = 10'h020; tick(); jump = 0;
        intr_en = 1; intr = 8'b0000_0110; tick();
        chk("irq pc", pc, 10'h3E4);
        chk("irq ack", intr_ack, 8'h02);
        chk("irq insvc", in_service, 8'h02);
        chk("irq sp", sp, 1);
        tick();
        chk("handler pc", pc, 10'h3E5);
        chk("ack pulse", intr_ack, 0);
        intr = 8'b0000_0111; tick();
`ifdef SECUENCIADOR_NESTED_INTR_EN
        chk("nest pc", pc, 10'h3E0);
        chk("nest sp", sp, 2);
        chk("nest insvc", in_service, 8'h03);
        chk("nest ack", intr_ack, 8'h01);
        intr = 0; reti = 1; tick();
        chk("reti1 pc", pc, 10'h3E5);
        chk("reti1 insvc", in_service, 8'h02);
        tick(); reti = 0;
        chk("reti2 pc", pc, 10'h020);
        chk("reti2 insvc", in_service, 0);
        chk("reti2 sp", sp, 0);
`else
        chk("blocked pc", pc, 10'h3E6);
        chk("blocked ack", intr_ack, 0);
        chk("blocked sp", sp, 1);
        intr = 8'b0000_0001; reti = 1; tick(); reti = 0;
        chk("reti pc", pc, 10'h020);
        chk("reti insvc", in_service, 0);
        chk("reti sp", sp, 0);
        tick();
        chk("pend pc", pc, 10'h3E0);
        chk("pend ack", intr_ack, 8'h01);
        chk("pend insvc", in_service, 8'h01);
        intr = 0; reti = 1; tick(); reti = 0;
        chk("reti2 pc", pc, 10'h020);
        chk("reti2 insvc", in_service, 0);
`endif

        // stall over jump + interrupt, interrupt wins on release
        stall = 1; jump = 1; target = 10'h055; intr = 8'h04;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall pc %0d", k), pc, 10'h020);
            chk($sformatf("stall ack %0d", k), intr_ack, 0);
        end
        stall = 0; tick();
        chk("release pc", pc, 10'h3E8);
        chk("release ack", intr_ack, 8'h04);
        chk("release insvc", in_service, 8'h04);
        jump = 0; intr = 0; tick();
        chk("release ack clr", intr_ack, 0);
        chk("release step pc", pc, 10'h3E9);
        reti = 1; tick(); reti = 0;
        chk("stall reti pc", pc, 10'h020);

        // PC wrap
        jump = 1; target = 10'h3FF; tick(); jump = 0;
        chk("wrap max", pc, 10'h3FF);
        tick();
        chk("wrap zero", pc, 0);
        chk("dut flags clean", {stack_ovf, stack_unf}, 0);

        // depth-2 instance: underflow, overflow, full-stack interrupt
        reset = 1; intr_en = 0; tick(); reset = 0;
        chk("d2 reset pc", pc2, 0);
        ret = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("d2 unf pc %0d", k), pc2, k);
        end
        ret = 0;
        chk("d2 unf", stack_unf2, 1);
        chk("d2 unf sp", sp2, 0);
        call = 1; target = 10'h100; tick();
        chk("d2 call1 sp", sp2, 1);
        target = 10'h200; tick(); call = 0;
        chk("d2 call2 pc", pc2, 10'h200);
        chk("d2 call2 sp", sp2, 2);
        intr_en = 1; intr = 8'h01; tick();
        chk("d2 full irq pc", pc2, 10'h201);
        chk("d2 full irq ack", intr_ack2, 0);
        chk("d2 full irq ovf", stack_ovf2, 0);
        intr = 0; call = 1; target = 10'h300; tick(); call = 0;
        chk("d2 call3 pc", pc2, 10'h300);
        chk("d2 call3 sp", sp2, 2);
        chk("d2 ovf", stack_ovf2, 1);
        ret = 1; tick();
        chk("d2 pop1 pc", pc2, 10'h101);
        tick(); ret = 0;
        chk("d2 pop2 pc", pc2, 10'h004);
        chk("d2 pop2 sp", sp2, 0);
        chk("d2 unf sticky", stack_unf2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
